// File: rtl/window_control.sv
// Window control: owns the current window pointer and window invalid mask for
// the 4-window register file, applies window moves, and raises overflow /
// underflow traps that are held until the trap unit acknowledges them.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | window ops accepted, one per cycle by priority
// TRAP_PEND | overflow/underflow trap waiting for TrapAck; SAVE/RESTORE/RETT
//           | dropped, trap entry and CWP writes still honoured
module window_control #(
   parameter int                  NWIN      = 4,
   parameter int                  CWP_W     = 2,
   parameter logic [CWP_W-1:0]    RESET_CWP = '0,
   parameter logic [NWIN-1:0]     RESET_WIM = 4'b0010
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Save,
   input  logic             Restore,
   input  logic             Rett,
   input  logic             TrapEntry,
   input  logic             WrCwpEn,
   input  logic [CWP_W-1:0] WrCwpData,
   input  logic             WrWimEn,
   input  logic [NWIN-1:0]  WrWimData,
   input  logic             TrapAck,
   output logic [CWP_W-1:0] CWP,
   output logic [NWIN-1:0]  WIM,
   output logic             TrapReq,
   output logic [1:0]       TrapType,
   output logic             Busy
);

   typedef enum logic {
      IDLE      = 1'b0,
      TRAP_PEND = 1'b1
   } state_t;

   localparam logic [1:0] TT_NONE  = 2'b00;
   localparam logic [1:0] TT_OVF   = 2'b01;
   localparam logic [1:0] TT_UNF   = 2'b10;

   state_t           state_q, state_d;
   logic [CWP_W-1:0] cwp_q, cwp_d;
   logic [NWIN-1:0]  wim_q, wim_d;
   logic             trap_req_q, trap_req_d;
   logic [1:0]       trap_type_q, trap_type_d;
   logic [CWP_W-1:0] cwp_dec, cwp_inc;

   // Neighbour windows; width-limited arithmetic gives the modulo-4 wrap.
   assign cwp_dec = cwp_q - CWP_W'(1);
   assign cwp_inc = cwp_q + CWP_W'(1);

   // State and window registers; reset wins over every other input.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= IDLE;
         cwp_q       <= RESET_CWP;
         wim_q       <= RESET_WIM;
         trap_req_q  <= 1'b0;
         trap_type_q <= TT_NONE;
      end else begin
         state_q     <= state_d;
         cwp_q       <= cwp_d;
         wim_q       <= wim_d;
         trap_req_q  <= trap_req_d;
         trap_type_q <= trap_type_d;
      end
   end

   // Next-state: prioritised window move plus independent WIM write; window
   // checks deliberately look at the pre-write WIM.
   always_comb begin
      state_d     = state_q;
      cwp_d       = cwp_q;
      wim_d       = WrWimEn ? WrWimData : wim_q;
      trap_req_d  = trap_req_q;
      trap_type_d = trap_type_q;

      case (state_q)
         IDLE: begin
            if (TrapEntry) begin
               cwp_d = cwp_dec;
            end else if (WrCwpEn) begin
               cwp_d = WrCwpData;
            end else if (Save) begin
               if (wim_q[cwp_dec]) begin
                  trap_req_d  = 1'b1;
                  trap_type_d = TT_OVF;
                  state_d     = TRAP_PEND;
               end else begin
                  cwp_d = cwp_dec;
               end
            end else if (Restore || Rett) begin
               if (wim_q[cwp_inc]) begin
                  trap_req_d  = 1'b1;
                  trap_type_d = TT_UNF;
                  state_d     = TRAP_PEND;
               end else begin
                  cwp_d = cwp_inc;
               end
            end
         end
         TRAP_PEND: begin
            if (TrapEntry) begin
               cwp_d = cwp_dec;
            end else if (WrCwpEn) begin
               cwp_d = WrCwpData;
            end
            if (TrapAck) begin
               trap_req_d  = 1'b0;
               trap_type_d = TT_NONE;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign CWP      = cwp_q;
   assign WIM      = wim_q;
   assign TrapReq  = trap_req_q;
   assign TrapType = trap_type_q;
   assign Busy     = (state_q == TRAP_PEND);

endmodule
